// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and helpers for the packet arbiter and its round-robin selector.
package axis_packet_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PASS = 2'b01
  } arb_state_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first requester after last_grant, with wrap-around.
module rr_priority_select #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  last_grant,
  output logic [SEL_WIDTH-1:0]  grant,
  output logic                  any_req
);

  logic [SEL_WIDTH-1:0] idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_INPUTS; i++) begin
      idx = SEL_WIDTH'((32'(last_grant) + i) % NUM_INPUTS);
      if (!any_req && req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_INPUTS AXIS sources onto one registered output.
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_INPUTS = 4,
  parameter  int unsigned AXIS_BYTES = 8,
  localparam int unsigned SEL_WIDTH  = sel_width(NUM_INPUTS)
) (
  input  logic                               clk,
  input  logic                               sreset,
  output logic [NUM_INPUTS-1:0]              axis_i_tready,
  input  logic [NUM_INPUTS-1:0]              axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]              axis_i_tlast,
  input  logic [NUM_INPUTS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                               axis_o_tready,
  output logic                               axis_o_tvalid,
  output logic                               axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]            axis_o_tdata,
  output logic [SEL_WIDTH-1:0]               axis_o_tsel
);

  localparam int unsigned DW = AXIS_BYTES * 8;

  arb_state_t           state, state_next;
  logic [SEL_WIDTH-1:0] grant, last_grant, rr_grant;
  logic                 rr_any;
  logic                 out_ready, accept, beat_last;
  logic [DW-1:0]        beat_data;

  rr_priority_select #(
    .NUM_INPUTS(NUM_INPUTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr (
    .req       (axis_i_tvalid),
    .last_grant(last_grant),
    .grant     (rr_grant),
    .any_req   (rr_any)
  );

  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    for (int unsigned n = 0; n < NUM_INPUTS; n++) begin
      if (SEL_WIDTH'(n) == grant) begin
        beat_data = axis_i_tdata[n*DW +: DW];
        beat_last = axis_i_tlast[n];
      end
    end
  end

  // tready depends only on the output register, never on other sources;
  // it is held low during reset so no beat is consumed and then discarded.
  always_comb begin
    out_ready     = !axis_o_tvalid || axis_o_tready;
    axis_i_tready = '0;
    accept        = 1'b0;
    state_next    = state;
    if (state == PASS && !sreset) begin
      axis_i_tready[grant] = out_ready;
      accept               = axis_i_tvalid[grant] && out_ready;
    end
    case (state)
      IDLE:    if (rr_any) state_next = PASS;
      PASS:    if (accept && beat_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sreset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      grant         <= '0;
      last_grant    <= SEL_WIDTH'(NUM_INPUTS - 1);
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tsel   <= '0;
      axis_o_tdata  <= '0;
    end else begin
      if (state == IDLE && rr_any) grant <= rr_grant;
      if (accept && beat_last)     last_grant <= grant;
      if (accept) begin
        axis_o_tvalid <= 1'b1;
        axis_o_tlast  <= beat_last;
        axis_o_tdata  <= beat_data;
        axis_o_tsel   <= grant;
      end else if (axis_o_tready) begin
        axis_o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-source beat stores, output monitor, cycle-exact checks.
module tb_axis_packet_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;

  logic           clk = 1'b0;
  logic           sreset;
  logic [N-1:0]   i_tready;
  logic [N-1:0]   i_tvalid = '0;
  logic [N-1:0]   i_tlast = '0;
  logic [N*W-1:0] i_tdata = '0;
  logic           o_tready;
  logic           o_tvalid;
  logic           o_tlast;
  logic [W-1:0]   o_tdata;
  logic [1:0]     o_tsel;

  int unsigned total = 0;
  int unsigned bad = 0;

  axis_packet_arbiter #(
    .NUM_INPUTS(N),
    .AXIS_BYTES(8)
  ) dut (
    .clk          (clk),
    .sreset       (sreset),
    .axis_i_tready(i_tready),
    .axis_i_tvalid(i_tvalid),
    .axis_i_tlast (i_tlast),
    .axis_i_tdata (i_tdata),
    .axis_o_tready(o_tready),
    .axis_o_tvalid(o_tvalid),
    .axis_o_tlast (o_tlast),
    .axis_o_tdata (o_tdata),
    .axis_o_tsel  (o_tsel)
  );

  always #5 clk = ~clk;

  // Source model: each source replays its stored beats, advancing on handshake.
  logic [W:0]  mem [N][32];
  int unsigned wr [N] = '{default: 0};
  int unsigned rd [N] = '{default: 0};
  logic        hold [N] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int n = 0; n < N; n++) begin
      i_tvalid[n] = (rd[n] != wr[n]) && !hold[n];
      {i_tlast[n], i_tdata[n*W +: W]} = mem[n][rd[n]];
    end
  end

  always @(posedge clk) begin
    for (int n = 0; n < N; n++)
      if (i_tvalid[n] && i_tready[n]) rd[n] <= rd[n] + 1;
  end

  // Output monitor: {tsel, tlast, tdata} of every beat taken downstream.
  logic [W+2:0] obs [128];
  int unsigned  obs_cyc [128];
  int unsigned  nobs = 0;
  int unsigned  cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_tvalid && o_tready) begin
      obs[nobs]     <= {o_tsel, o_tlast, o_tdata};
      obs_cyc[nobs] <= cyc;
      nobs          <= nobs + 1;
    end
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input int n, input logic [W-1:0] d, input logic l);
    mem[n][wr[n]] = {l, d};
    wr[n] = wr[n] + 1;
  endtask

  task automatic wait_obs(input int unsigned target, input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget && nobs < target; i++) step(1);
    chk(tag, 72'(nobs >= target), 72'(1));
  endtask

  logic [7:0]  t2_data [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
  logic [1:0]  t2_sel  [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [63:0] t3_data [4]  = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
  int unsigned base;

  initial begin
    sreset   = 1'b1;
    o_tready = 1'b1;
    step(3);
    chk("rst_ovalid", 72'(o_tvalid), 72'(0));
    chk("rst_olast", 72'(o_tlast), 72'(0));
    chk("rst_tsel", 72'(o_tsel), 72'(0));
    chk("rst_itready", 72'(i_tready), 72'(0));

    // Single source, 3-beat packet
    sreset = 1'b0;
    push(2, 64'h11, 1'b0); push(2, 64'h22, 1'b0); push(2, 64'h33, 1'b1);
    step(1);
    chk("t1_grant_ready", 72'(i_tready), 72'(4'b0100));
    chk("t1_no_out_yet", 72'(o_tvalid), 72'(0));
    step(1);
    chk("t1_beat0", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd2, 1'b0, 64'h11});
    step(1);
    chk("t1_beat1", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd2, 1'b0, 64'h22});
    step(1);
    chk("t1_beat2", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd2, 1'b1, 64'h33});
    chk("t1_idle_ready", 72'(i_tready), 72'(0));
    step(1);
    chk("t1_drained", 72'(o_tvalid), 72'(0));

    // Round robin from reset: all four sources queued
    sreset = 1'b1;
    step(1);
    sreset = 1'b0;
    base = nobs;
    for (int s = 0; s < N; s++) begin
      push(s, 64'(s * 16), 1'b0);
      push(s, 64'(s * 16 + 1), 1'b1);
    end
    push(0, 64'h02, 1'b0); push(0, 64'h03, 1'b1);
    wait_obs(base + 10, 80, "t2_complete");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_beat%0d", i), 72'(obs[base + i]),
          72'({t2_sel[i], i[0], 56'd0, t2_data[i]}));
      if (i > 0)
        chk($sformatf("t2_spacing%0d", i), 72'(obs_cyc[base + i] - obs_cyc[base + i - 1]),
            72'(i[0] ? 1 : 2));
    end
    step(2);

    // Back-pressure during a 4-beat packet from source 1
    base = nobs;
    for (int b = 0; b < 4; b++) push(1, t3_data[b], b == 3);
    step(1);
    chk("t3_grant_ready", 72'(i_tready), 72'(4'b0010));
    step(1);
    chk("t3_b0", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd1, 1'b0, 64'hB0});
    o_tready = 1'b0;
    #1;
    chk("t3_stall_ready0", 72'(i_tready), 72'(0));
    step(1);
    chk("t3_hold1", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd1, 1'b0, 64'hB0});
    chk("t3_stall_ready1", 72'(i_tready), 72'(0));
    step(1);
    chk("t3_hold2", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd1, 1'b0, 64'hB0});
    o_tready = 1'b1;
    #1;
    chk("t3_resume_ready", 72'(i_tready), 72'(4'b0010));
    step(1);
    chk("t3_b1", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd1, 1'b0, 64'hB1});
    step(1);
    chk("t3_b2", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd1, 1'b0, 64'hB2});
    step(1);
    chk("t3_b3", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd1, 1'b1, 64'hB3});
    step(1);
    chk("t3_count", 72'(nobs - base), 72'(4));
    for (int b = 0; b < 4; b++)
      chk($sformatf("t3_obs%0d", b), 72'(obs[base + b]), 72'({2'd1, b == 3, t3_data[b]}));
    step(1);

    // Granted source pauses 5 cycles while source 3 waits
    push(0, 64'hC0, 1'b0); push(0, 64'hC1, 1'b0); push(0, 64'hC2, 1'b0); push(0, 64'hC3, 1'b1);
    step(1);
    push(3, 64'hD0, 1'b1);
    chk("t4_grant_ready", 72'(i_tready), 72'(4'b0001));
    step(2);
    hold[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk($sformatf("t4_gap_ready%0d", k), 72'(i_tready), 72'(4'b0001));
    end
    chk("t4_gap_ovalid", 72'(o_tvalid), 72'(0));
    hold[0] = 1'b0;
    step(1);
    chk("t4_c2", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd0, 1'b0, 64'hC2});
    step(1);
    chk("t4_c3", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd0, 1'b1, 64'hC3});
    step(1);
    chk("t4_src3_ready", 72'(i_tready), 72'(4'b1000));
    step(1);
    chk("t4_d0", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd3, 1'b1, 64'hD0});
    step(2);

    // Reset after 2 of 4 beats
    for (int b = 0; b < 4; b++) push(2, 64'(8'hE0 + b), b == 3);
    step(1);
    chk("t5_grant_ready", 72'(i_tready), 72'(4'b0100));
    step(2);
    chk("t5_e1", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd2, 1'b0, 64'hE1});
    sreset = 1'b1;
    push(0, 64'hF0, 1'b1);
    step(1);
    chk("t5_rst_ovalid", 72'(o_tvalid), 72'(0));
    chk("t5_rst_ready", 72'(i_tready), 72'(0));
    sreset = 1'b0;
    step(1);
    chk("t5_src0_first", 72'(i_tready), 72'(4'b0001));
    step(1);
    chk("t5_f0", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd0, 1'b1, 64'hF0});
    step(1);
    chk("t5_src2_regrant", 72'(i_tready), 72'(4'b0100));
    step(1);
    chk("t5_e2", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd2, 1'b0, 64'hE2});
    step(1);
    chk("t5_e3", {o_tvalid, o_tsel, o_tlast, o_tdata}, {1'b1, 2'd2, 1'b1, 64'hE3});
    step(2);

    // Alternating single-beat packets from sources 0 and 1
    base = nobs;
    for (int k = 0; k < 3; k++) begin
      push(0, 64'(8'h50 + 2 * k), 1'b1);
      push(1, 64'(8'h51 + 2 * k), 1'b1);
    end
    wait_obs(base + 6, 40, "t6_complete");
    for (int i = 0; i < 6; i++)
      chk($sformatf("t6_beat%0d", i), 72'(obs[base + i]),
          72'({2'(i % 2), 1'b1, 64'(8'h50 + i)}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one AXIS path between NUM_INPUTS wide packet sources.
- Typically sits in front of axis_unpacker, so several MAC/packet generators share one byte-wide egress.
- A grant is held from the first beat of a packet until its tlast beat is accepted; packets are never interleaved.
- The output is registered (one-entry pipeline) so the unpacker's tready is not combinationally fed back to every source.

Parameters:
- NUM_INPUTS, 4, number of requesting AXIS sources (2..16).
- AXIS_BYTES, 8, tdata width in bytes, same on every input and on the output.
- SEL_WIDTH, derived: NUM_INPUTS==1 ? 1 : $clog2(NUM_INPUTS); localparam, not overridable.

Ports:
- clk  in  1  single clock.
- sreset  in  1  synchronous reset, active-high.
- axis_i_tready  out  NUM_INPUTS  per-source ready; bit n belongs to source n.
- axis_i_tvalid  in  NUM_INPUTS  per-source valid.
- axis_i_tlast  in  NUM_INPUTS  per-source last.
- axis_i_tdata  in  NUM_INPUTS*AXIS_BYTES*8  source n occupies bits [(n+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8].
- axis_o_tready  in  1  downstream ready.
- axis_o_tvalid  out  1  registered valid.
- axis_o_tlast  out  1  registered last.
- axis_o_tdata  out  AXIS_BYTES*8  registered data.
- axis_o_tsel  out  SEL_WIDTH  index of the source of the current output beat; registered with tdata.

Behaviour:
- Reset (sreset=1 at a clk edge):
  - state=IDLE; axis_o_tvalid=0, axis_o_tlast=0, axis_o_tsel=0.
  - axis_i_tready all 0; last_grant=NUM_INPUTS-1, so source 0 has top priority first.
  - tdata is don't-care.
  - Reset mid-packet abandons the packet. No tlast is emitted for it, and the remaining beats of the source are arbitrated as a new packet.
- State IDLE:
  - axis_i_tready all 0.
  - If any axis_i_tvalid bit is set: grant <= first n with tvalid[n]=1, searching (last_grant+1) mod N, (last_grant+2) mod N, ... with wrap-around. Then state <= PASS.
  - Otherwise stay in IDLE.
- State PASS:
  - axis_i_tready[grant] = (!axis_o_tvalid || axis_o_tready); all other bits are 0. This is combinational from the output register state only, never from other sources' tvalid.
  - When a beat is accepted (tvalid & tready on grant), the output register loads tdata/tlast, and tsel<=grant, tvalid<=1, next cycle.
  - When the accepted beat has tlast=1: last_grant<=grant, state<=IDLE.
  - Sources without a grant are ignored in PASS; their tvalid is never dropped.
- Output register:
  - axis_o_tvalid clears when axis_o_tready=1 and no new beat loads in the same cycle.
  - A simultaneous drain and load keeps tvalid=1 with the new beat, giving full throughput of one beat per cycle.
- Latency:
  - Arbitration costs one cycle: the first beat is accepted no earlier than the cycle after IDLE sees tvalid.
  - Input-to-output latency is 1 cycle.
  - Inter-packet gap on the output is 1 cycle minimum.
- Boundary conditions:
  - Single-beat packet (tvalid & tlast on the first beat): PASS lasts exactly one accept.
  - A source deasserting tvalid mid-packet holds the grant; the arbiter waits indefinitely with no timeout.
  - NUM_INPUTS=1 degenerates to a registered pipe with a 1-cycle gap per packet.
  - axis_o_tready held low: the output register stays stable (AXIS rule), and all tready are 0 once tvalid=1.
- Fairness: after a packet from source k completes, source k has the lowest priority in the next IDLE decision.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'b00, PASS=2'b01), matching the existing CAPTURE/OUTPUT style;
  - a constant function for SEL_WIDTH.
- One natural sub-module: rr_priority_select. It is combinational: inputs are a request vector and last_grant; outputs are grant index and any_req. It is reusable by other schedulers.
- The output register stays inline.

Test Plan:
- Single source: source 2 sends a 3-beat packet 0x11,0x22,0x33 (tlast on 0x33), axis_o_tready=1 → output beats 0x11,0x22,0x33 on consecutive cycles, tsel=2, tlast only on 0x33, first output 2 cycles after the first tvalid.
- Round robin: all 4 sources hold a 2-beat packet from reset → output packet order is 0,1,2,3,0; no beat of one packet is interleaved with another; one idle cycle between packets.
- Back-pressure: axis_o_tready toggles 1,0,0,1 during a 4-beat packet → no beat lost or duplicated, tdata stable while tvalid=1 and tready=0, and axis_i_tready[grant]=0 while the register is full and stalled.
- Source gap: the granted source drops tvalid for 5 cycles mid-packet while source 3 is valid → axis_i_tready[3] stays 0 and the packet resumes without a grant change.
- Reset mid-packet: sreset asserted after beat 2 of 4 → next cycle axis_o_tvalid=0 and all tready=0; after release source 0 wins first.
- Single-beat packets: sources 0 and 1 alternate 1-beat packets → tsel alternates 0,1 with tlast=1 on every output beat.
